// File: rtl/multiplier_iterative_if.sv
// Request/response bundle for the iterative multiplier: operands in, product out.
interface multiplier_iterative_if #(
    parameter int WIDTH = 32
);
    logic               valid_in;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               valid_out;
    logic [2*WIDTH-1:0] r;

    modport master (output valid_in, output a, output b, input valid_out, input r);
    modport slave  (input valid_in, input a, input b, output valid_out, output r);
endinterface

// File: rtl/multiplier_iterative.sv
// Shift-and-add unsigned multiplier, one multiplier bit per clock (MULTIPLIER_ITERATIVE_EARLY_TERM_EN: stop once mplier is exhausted).
// Latency WIDTH cycles from acceptance (early-term: highest set bit of b + 1, minimum 1).
// No backpressure: requests while BUSY are dropped; the product holds until the next accepted request.
module multiplier_iterative #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multiplier_iterative_if.slave mul
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   r_q, r_d;
    logic                 valid_out_q, valid_out_d;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            r_q         <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            r_q         <= r_d;
            valid_out_q <= valid_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        r_d         = r_q;
        valid_out_d = valid_out_q;

        acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef MULTIPLIER_ITERATIVE_EARLY_TERM_EN
        // Remaining multiplier bits all zero: further iterations cannot change acc.
        last = (count_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
        last = (count_q == CW'(WIDTH - 1));
`endif

        case (state_q)
            IDLE, DONE: begin
                if (mul.valid_in) begin
                    mcand_d     = {{WIDTH{1'b0}}, mul.a};
                    mplier_d    = mul.b;
                    acc_d       = '0;
                    count_d     = '0;
                    valid_out_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (last) begin
                    r_d         = acc_sum;
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mul.valid_out = valid_out_q;
    assign mul.r         = r_q;
endmodule

// File: tb/tb_multiplier_iterative.sv
// Randomized bench: products and completion latency checked against plain 64-bit arithmetic.
module tb_multiplier_iterative;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    multiplier_iterative_if #(.WIDTH(32)) mul ();

    multiplier_iterative #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mul   (mul.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] bv);
`ifdef MULTIPLIER_ITERATIVE_EARLY_TERM_EN
        int hb;
        hb = 0;
        for (int i = 0; i < 32; i++) if (bv[i]) hb = i + 1;
        return (hb < 1) ? 1 : hb;
`else
        return 32;
`endif
    endfunction

    // One request; optionally disturbs inputs while busy and pulses valid_in on cycle 10.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input bit scramble);
        int lat;
        logic [63:0] prod;
        prod = {32'd0, ta} * {32'd0, tbv};
        @(negedge clk);
        mul.valid_in = 1'b1;
        mul.a = ta;
        mul.b = tbv;
        @(posedge clk);
        #1;
        mul.valid_in = 1'b0;
        check({tag, "_vout_low"}, {63'd0, mul.valid_out}, 64'd0);
        lat = 0;
        while (!mul.valid_out && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (scramble) begin
                mul.a = $urandom;
                mul.b = $urandom;
                mul.valid_in = (lat == 9);
            end
        end
        mul.valid_in = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_latency(tbv)));
        check({tag, "_r"}, mul.r, prod);
    endtask

    initial begin
        logic [31:0] pa, pb;
        n_tests = 0;
        n_fail  = 0;
        mul.valid_in = 1'b0;
        mul.a = '0;
        mul.b = '0;
        reset = 1'b1;
        #12;
        check("reset_vout", {63'd0, mul.valid_out}, 64'd0);
        check("reset_r", mul.r, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("pre_reset", 32'd123, 32'd456, 1'b0);
        // Asynchronous reset mid-cycle with a request presented during it.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_vout", {63'd0, mul.valid_out}, 64'd0);
        check("async_reset_r", mul.r, 64'd0);
        mul.valid_in = 1'b1;
        mul.a = 32'd5;
        mul.b = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        mul.valid_in = 1'b0;
        check("reset_ignore_vout", {63'd0, mul.valid_out}, 64'd0);
        check("reset_ignore_r", mul.r, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_idle_vout", {63'd0, mul.valid_out}, 64'd0);

        for (int i = 0; i < 100; i++) run_op("sweep", 32'd1, 32'(i), 1'b0);

        pa = 32'd0;
        pb = 32'd0;
        for (int i = 0; i < 100; i++) begin
            pa = pa + 32'h23456789;
            pb = pb + 32'h34567891;
            run_op("walk", pa, pb, 1'b0);
        end
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("zero_a", 32'd0, 32'hDEAD_BEEF, 1'b0);
        run_op("zero_b", 32'hDEAD_BEEF, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) run_op("rand", $urandom, $urandom, 1'b0);

        run_op("busy_interf", 32'd3, 32'd4, 1'b1);
        // Product must hold through DONE.
        repeat (10) @(posedge clk);
        #1;
        check("done_hold_vout", {63'd0, mul.valid_out}, 64'd1);
        check("done_hold_r", mul.r, 64'd12);

        @(negedge clk);
        mul.valid_in = 1'b1;
        mul.a = 32'd1000;
        mul.b = 32'd1000;
        @(posedge clk);
        #1 mul.valid_in = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midop_reset_vout", {63'd0, mul.valid_out}, 64'd0);
        check("midop_reset_r", mul.r, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_midop", 32'd6, 32'd7, 1'b0);

        run_op("b_one", 32'd10, 32'd1, 1'b0);
        run_op("b_msb", 32'd10, 32'h8000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/multiplier_iterative.md
Name: multiplier_iterative

Overview:
- Iterative unsigned integer multiplier using a shift-and-add datapath: one multiplier bit is processed per clock.
- Accepts a single-cycle valid_in request, computes a*b over WIDTH cycles, then presents a 2*WIDTH-bit product with valid_out held high.
- Small-area alternative to a combinational multiplier, for use in the CPU datapath or standalone arithmetic units.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  start request; a and b are sampled on the rising edge where valid_in=1 and the unit is IDLE or DONE.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- valid_out  output  1  product valid; held until the next accepted request.
- r  output  2*WIDTH  product a*b, unsigned.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-high reset (reset).
- Reset response: state=IDLE, valid_out=0, r=0, internal registers cleared immediately, independent of clk.
- States:
  - IDLE: waiting, valid_out=0.
  - BUSY: iterating.
  - DONE: valid_out=1.
- Acceptance:
  - In IDLE or DONE, valid_in=1 at a rising edge latches a into mcand (2*WIDTH, zero-extended), latches b into mplier (WIDTH), clears acc, sets count=0, clears valid_out and goes to BUSY.
  - valid_out falls on that same edge.
- BUSY, each edge:
  - If mplier[0]=1: acc <= acc + mcand, computed mod 2^(2*WIDTH); no overflow is possible.
  - Then mcand <<= 1, mplier >>= 1, count++.
  - After the WIDTH-th iteration: r <= final acc, valid_out <= 1, go to DONE.
- Latency: request accepted at edge k; valid_out=1 and r valid after edge k+WIDTH (32 cycles by default).
- Throughput: one product per WIDTH+1 cycles when requests are issued back-to-back.
- valid_in during BUSY: ignored. No queuing; the operation in flight is unaffected.
- Operands: a and b only need to be stable on the accepting edge. Later changes have no effect on the operation in flight.
- r holds its value through IDLE and DONE. It updates only at completion, never with partial sums.
- DONE: valid_out and r stay stable indefinitely until a new request is accepted or reset is asserted.
- Reset mid-operation: the computation is aborted and the unit returns to IDLE with all outputs zero.
- Zero operands follow the normal path with the same latency; the result is 0.

Optional Feature:
- Macro: MULTIPLIER_ITERATIVE_EARLY_TERM_EN.
- Defined: in BUSY, when mplier becomes 0 after a shift, the unit completes on that edge. r <= acc, valid_out=1, go to DONE. Latency becomes max(1, index of highest set bit of b + 1) cycles; b=0 completes 1 cycle after acceptance.
- Undefined: fixed WIDTH-cycle latency as specified above.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> valid_out=0, r=0 immediately; pulse valid_in with a=5, b=7 during reset -> ignored.
- Sweep: a=1, b=0..99, one request each, wait for valid_out -> r=b each time; valid_out low on the cycle after acceptance, high exactly 32 edges after acceptance (no macro).
- Pseudo-random: a+=0x23456789, b+=0x34567891 (mod 2^32) for 100 operations -> r==a*b (64-bit) every time, including a=b=0xFFFFFFFF -> r=0xFFFFFFFE00000001.
- Busy interference: start a=3, b=4; pulse valid_in with a=9, b=9 at cycle 10 and change a/b every cycle -> r=12; valid_out rises at the original latency.
- Reset mid-operation: start a=1000, b=1000, assert reset at cycle 15 -> IDLE, valid_out=0, r=0; new request a=6, b=7 -> r=42.
- Early termination (macro defined): a=10, b=1 -> valid_out 1 cycle after acceptance, r=10; b=0x80000000 -> 32 cycles.
